// File: rtl/circuit_breaker_ctrl.sv
// Trading circuit breaker: HALT -> COOLDOWN -> IDLE sequencing with retrip escalation.
// Optional lockout on repeated trips is enabled by defining CB_LOCKOUT_EN.
`timescale 1ns/1ps
module circuit_breaker_ctrl #(
  parameter int unsigned COOLDOWN_CYCLES = 16,
  parameter int unsigned LOCKOUT_TRIPS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cb_load,
  input  logic [7:0] cb_param,
  input  logic [1:0] cb_type,
  input  logic       manual_release,
  output logic       trade_enable,
  output logic       throttle,
  output logic [1:0] cb_state,
  output logic [7:0] remaining,
  output logic       trip_pulse,
  output logic [7:0] trip_count,
  output logic [1:0] last_type
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HALT     = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_LOCKOUT  = 2'd3
  } cb_state_e;

  localparam logic [7:0] COOL_LEN   = 8'(COOLDOWN_CYCLES);
  localparam logic [3:0] LOCK_TRIPS = 4'(LOCKOUT_TRIPS);

  cb_state_e  state_r;
  logic [7:0] remaining_r;
  logic [3:0] retrip_r;
  logic [7:0] trip_count_r;
  logic [1:0] last_type_r;
  logic       trip_pulse_r;
  logic       trade_enable_r;
  logic       throttle_r;

  cb_state_e  state_s;
  logic [7:0] remaining_s;
  logic [3:0] retrip_s;
  logic       accept_s;
  logic [3:0] retrip_inc_s;
  logic       lock_hit_s;
  logic [7:0] rem_dec_s;
  logic       trade_enable_s;
  logic       throttle_s;

  // Trips are dead while locked out; a zero-length halt request is not a trip.
  assign accept_s  = cb_load && (cb_param != 8'd0) && (state_r != ST_LOCKOUT);
  assign rem_dec_s = remaining_r - 8'd1;

`ifdef CB_LOCKOUT_EN
  assign retrip_inc_s = retrip_r + 4'd1;
  assign lock_hit_s   = (retrip_inc_s == LOCK_TRIPS);
`else
  logic unused_release_s;
  assign unused_release_s = manual_release;
  assign retrip_inc_s     = (retrip_r >= LOCK_TRIPS) ? LOCK_TRIPS : (retrip_r + 4'd1);
  assign lock_hit_s       = 1'b0;
`endif

  // Next-state, remaining-cycle and retrip-counter logic.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    retrip_s    = retrip_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s     = ST_HALT;
          remaining_s = cb_param;
          retrip_s    = 4'd1;
        end else begin
          remaining_s = 8'd0;
        end
      end
      ST_HALT: begin
        if (accept_s) begin
          retrip_s = retrip_inc_s;
          if (lock_hit_s) begin
            state_s     = ST_LOCKOUT;
            remaining_s = 8'd0;
          end else begin
            // A retrip may lengthen the halt but never shorten it.
            remaining_s = (rem_dec_s > cb_param) ? rem_dec_s : cb_param;
          end
        end else if (remaining_r == 8'd1) begin
          state_s     = ST_COOLDOWN;
          remaining_s = COOL_LEN;
        end else begin
          remaining_s = rem_dec_s;
        end
      end
      ST_COOLDOWN: begin
        if (accept_s) begin
          retrip_s = retrip_inc_s;
          if (lock_hit_s) begin
            state_s     = ST_LOCKOUT;
            remaining_s = 8'd0;
          end else begin
            state_s     = ST_HALT;
            remaining_s = cb_param;
          end
        end else if (remaining_r == 8'd1) begin
          state_s     = ST_IDLE;
          remaining_s = 8'd0;
          retrip_s    = 4'd0;
        end else begin
          remaining_s = rem_dec_s;
        end
      end
      ST_LOCKOUT: begin
        remaining_s = 8'd0;
`ifdef CB_LOCKOUT_EN
        if (manual_release) begin
          state_s  = ST_IDLE;
          retrip_s = 4'd0;
        end else begin
          state_s = ST_LOCKOUT;
        end
`else
        state_s  = ST_IDLE;
        retrip_s = 4'd0;
`endif
      end
      default: begin
        state_s     = ST_IDLE;
        remaining_s = 8'd0;
        retrip_s    = 4'd0;
      end
    endcase
  end

  // Output flags decoded from the upcoming state so they register alongside it.
  always_comb begin
    trade_enable_s = 1'b0;
    throttle_s     = 1'b0;
    case (state_s)
      ST_IDLE:     trade_enable_s = 1'b1;
      ST_COOLDOWN: begin
        trade_enable_s = 1'b1;
        throttle_s     = 1'b1;
      end
      ST_HALT:     trade_enable_s = 1'b0;
      ST_LOCKOUT:  trade_enable_s = 1'b0;
      default:     trade_enable_s = 1'b0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      remaining_r    <= 8'd0;
      retrip_r       <= 4'd0;
      trip_count_r   <= 8'd0;
      last_type_r    <= 2'd0;
      trip_pulse_r   <= 1'b0;
      trade_enable_r <= 1'b1;
      throttle_r     <= 1'b0;
    end else begin
      state_r        <= state_s;
      remaining_r    <= remaining_s;
      retrip_r       <= retrip_s;
      trip_pulse_r   <= accept_s;
      trade_enable_r <= trade_enable_s;
      throttle_r     <= throttle_s;
      if (accept_s) begin
        last_type_r <= cb_type;
        if (trip_count_r != 8'hFF) begin
          trip_count_r <= trip_count_r + 8'd1;
        end
      end
    end
  end

  assign cb_state     = state_r;
  assign remaining    = remaining_r;
  assign trip_count   = trip_count_r;
  assign last_type    = last_type_r;
  assign trip_pulse   = trip_pulse_r;
  assign trade_enable = trade_enable_r;
  assign throttle     = throttle_r;

endmodule
